mux4_tdm_rr: RTL and testbench

- Gathering end of the 1x4 demux path. Four producer channels each offer a data word with a valid/ready handshake.
- A round-robin arbiter picks one word per transfer and registers it onto a single output stream as a data word `a` plus channel select `s`.
- That pair feeds a demux1_4-style fan-out downstream, so the select-plus-data format matches what the demux consumes.

---
 rtl/mux4_tdm_rr.sv | 115 +++++++++++
 tb/tb_mux4_tdm_rr.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mux4_tdm_rr.sv
// ============================================================================
// Module   : mux4_tdm_rr
// Brief    : 4:1 valid/ready gatherer with round-robin arbitration and a
//            registered select+data output for a downstream 1:4 demux.
//            Define MUX4_FIXED_PRIO_EN for fixed priority (ch0 highest).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux4_tdm_rr #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        in_valid,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [DATA_W-1:0] in_data3,
   output logic [3:0]        in_ready,
   output logic [DATA_W-1:0] a,
   output logic [1:0]        s,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [1:0]        s_q, s_d;
   logic [1:0]        rr_ptr;
   logic              load_en;
   logic              found;
   logic [1:0]        win;
   logic              grant;

`ifdef MUX4_FIXED_PRIO_EN
   assign rr_ptr = 2'b00;
`else
   logic [1:0] rr_ptr_q, rr_ptr_d;
   assign rr_ptr = rr_ptr_q;
`endif

   // Scan starts at rr_ptr; the first valid channel in rotated order wins.
   always_comb begin
      found = 1'b0;
      win   = 2'b00;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] idx;
         idx = rr_ptr + k[1:0];
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign load_en = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
   assign grant   = found & load_en & ~rst;

   always_comb begin
      in_ready = 4'b0000;
      state_d  = state_q;
      a_d      = a_q;
      s_d      = s_q;
`ifndef MUX4_FIXED_PRIO_EN
      rr_ptr_d = rr_ptr_q;
`endif
      if (grant) begin
         in_ready[win] = 1'b1;
         state_d       = FULL;
         s_d           = win;
`ifndef MUX4_FIXED_PRIO_EN
         rr_ptr_d      = win + 2'd1;
`endif
         case (win)
            2'd0:    a_d = in_data0;
            2'd1:    a_d = in_data1;
            2'd2:    a_d = in_data2;
            default: a_d = in_data3;
         endcase
      end else if ((state_q == FULL) && out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         a_q      <= '0;
         s_q      <= 2'b00;
`ifndef MUX4_FIXED_PRIO_EN
         rr_ptr_q <= 2'b00;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         s_q      <= s_d;
`ifndef MUX4_FIXED_PRIO_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign a         = a_q;
   assign s         = s_q;
   assign out_valid = (state_q == FULL);

endmodule

`default_nettype wire

// File: tb/tb_mux4_tdm_rr.sv
// ============================================================================
// Module   : tb_mux4_tdm_rr
// Brief    : Directed vector bench for mux4_tdm_rr (either arbitration build).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux4_tdm_rr;

`ifdef MUX4_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_valid;
   logic [7:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0] in_ready;
   logic [7:0] a;
   logic [1:0] s;
   logic       out_valid;
   logic       out_ready;

   int applied = 0;
   int errors  = 0;

   mux4_tdm_rr #(.DATA_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .a         (a),
      .s         (s),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] iv;
      logic [7:0] d0, d1, d2, d3;
      logic       ordy;
      logic [3:0] e_ir;   // in_ready just before the edge
      logic [7:0] e_a;    // outputs just after the edge
      logic [1:0] e_s;
      logic       e_ov;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] iv,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input logic ordy, input logic [3:0] e_ir,
                      input logic [7:0] e_a, input logic [1:0] e_s,
                      input logic e_ov);
      vec_t v;
      v.rst = r; v.iv = iv; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
      v.ordy = ordy; v.e_ir = e_ir; v.e_a = e_a; v.e_s = e_s; v.e_ov = e_ov;
      vecs.push_back(v);
   endtask

   // Drive one vector, check in_ready before the edge and a/s/out_valid after.
   task automatic apply(input string name, input vec_t v);
      logic [3:0] ir_seen;
      rst = v.rst; in_valid = v.iv; out_ready = v.ordy;
      in_data0 = v.d0; in_data1 = v.d1; in_data2 = v.d2; in_data3 = v.d3;
      #1;
      ir_seen = in_ready;
      @(posedge clk);
      #1;
      applied++;
      if (ir_seen !== v.e_ir || a !== v.e_a || s !== v.e_s || out_valid !== v.e_ov) begin
         errors++;
         $display("FAIL %s: got in_ready=%b a=%h s=%b out_valid=%b, want in_ready=%b a=%h s=%b out_valid=%b",
                  name, ir_seen, a, s, out_valid, v.e_ir, v.e_a, v.e_s, v.e_ov);
      end
   endtask

   initial begin
      vec_t v;
      // reset with all channels valid
      add(1, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 8'h00, 2'd0, 0);
      add(1, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 8'h00, 2'd0, 0);
      // fairness: all valid, ptr starts at 0
      add(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 8'h10, 2'd0, 1);
      add(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1,
          FIXED ? 4'b0001 : 4'b0010, FIXED ? 8'h10 : 8'h11, FIXED ? 2'd0 : 2'd1, 1);
      add(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1,
          FIXED ? 4'b0001 : 4'b0100, FIXED ? 8'h10 : 8'h12, FIXED ? 2'd0 : 2'd2, 1);
      add(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1,
          FIXED ? 4'b0001 : 4'b1000, FIXED ? 8'h10 : 8'h13, FIXED ? 2'd0 : 2'd3, 1);
      add(0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 8'h10, 2'd0, 1);
      // drain without refill
      add(0, 4'b0000, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 8'h10, 2'd0, 0);
      // single channel 2
      add(0, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00, 1, 4'b0100, 8'hA5, 2'd2, 1);
      add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000, 8'hA5, 2'd2, 0);
      // wrap and skip: ptr=3 (RR), ch0 then ch1
      add(0, 4'b0011, 8'h20, 8'h21, 8'h00, 8'h00, 1, 4'b0001, 8'h20, 2'd0, 1);
      add(0, 4'b0011, 8'h20, 8'h21, 8'h00, 8'h00, 1,
          FIXED ? 4'b0001 : 4'b0010, FIXED ? 8'h20 : 8'h21, FIXED ? 2'd0 : 2'd1, 1);
      add(0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'b0000,
          FIXED ? 8'h20 : 8'h21, FIXED ? 2'd0 : 2'd1, 0);
      // backpressure: load 3C, stall 3 cycles with ch1 valid, then release
      add(0, 4'b0001, 8'h3C, 8'h00, 8'h00, 8'h00, 1, 4'b0001, 8'h3C, 2'd0, 1);
      add(0, 4'b0010, 8'h00, 8'h44, 8'h00, 8'h00, 0, 4'b0000, 8'h3C, 2'd0, 1);
      add(0, 4'b0010, 8'h00, 8'h44, 8'h00, 8'h00, 0, 4'b0000, 8'h3C, 2'd0, 1);
      add(0, 4'b0010, 8'h00, 8'h44, 8'h00, 8'h00, 0, 4'b0000, 8'h3C, 2'd0, 1);
      add(0, 4'b0010, 8'h00, 8'h44, 8'h00, 8'h00, 1, 4'b0010, 8'h44, 2'd1, 1);
      // mid-operation reset discards the pending word
      add(1, 4'b0100, 8'h00, 8'h00, 8'h55, 8'h00, 0, 4'b0000, 8'h00, 2'd0, 0);
      add(0, 4'b0000, 8'h00, 8'h00, 8'h55, 8'h00, 1, 4'b0000, 8'h00, 2'd0, 0);
      // pointer restarts at 0 after reset
      add(0, 4'b1010, 8'h00, 8'h66, 8'h00, 8'h77, 1, 4'b0010, 8'h66, 2'd1, 1);
      add(0, 4'b1010, 8'h00, 8'h66, 8'h00, 8'h77, 1,
          FIXED ? 4'b0010 : 4'b1000, FIXED ? 8'h66 : 8'h77, FIXED ? 2'd1 : 2'd3, 1);

      foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

      // Hand sequence: idle cycles must not move the pointer (RR ptr is 0 here).
      for (int k = 0; k < 3; k++) begin
         v.rst = 0; v.iv = 4'b0000; v.d0 = 8'h00; v.d1 = 8'h00; v.d2 = 8'h00; v.d3 = 8'h00;
         v.ordy = 1; v.e_ir = 4'b0000;
         v.e_a = FIXED ? 8'h66 : 8'h77; v.e_s = FIXED ? 2'd1 : 2'd3; v.e_ov = 0;
         apply($sformatf("idle%0d", k), v);
      end
      v.iv = 4'b1111; v.d0 = 8'h81; v.d1 = 8'h82; v.d2 = 8'h83; v.d3 = 8'h84;
      v.e_ir = 4'b0001; v.e_a = 8'h81; v.e_s = 2'd0; v.e_ov = 1;
      apply("idle_ptr_hold", v);

      // Hand sequence: data changing during a stall is only sampled on accept.
      v.iv = 4'b0100; v.ordy = 0; v.e_ir = 4'b0000; v.e_a = 8'h81; v.e_s = 2'd0; v.e_ov = 1;
      v.d2 = 8'h90; apply("stall_chg0", v);
      v.d2 = 8'h91; apply("stall_chg1", v);
      v.d2 = 8'h92; v.ordy = 1; v.e_ir = 4'b0100; v.e_a = 8'h92; v.e_s = 2'd2;
      apply("stall_accept", v);

      $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
      $finish;
   end

endmodule

`default_nettype wire
